// File: rtl/i8080_pkg.sv
// i8080_pkg: types and constants shared by the 8080 fetch and decode stages.
package i8080_pkg;

  typedef logic [1:0]  ins_len_t;
  typedef logic [15:0] addr_t;

  localparam ins_len_t INS_LEN_1 = 2'd1;
  localparam ins_len_t INS_LEN_2 = 2'd2;
  localparam ins_len_t INS_LEN_3 = 2'd3;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory read port plus decode-side instruction handshake of the fetch queue.
// master = fetch_queue, slave = memory/decode side.
interface fetch_queue_if;
  import i8080_pkg::*;

  logic        mem_rd_en;
  addr_t       mem_raddr;
  logic [15:0] mem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [23:0] ins_data;
  ins_len_t    ins_len;
  addr_t       ins_pc;

  modport master (
    output mem_rd_en, mem_raddr, ins_valid, ins_data, ins_len, ins_pc,
    input  mem_rdata, ins_ready
  );

  modport slave (
    input  mem_rd_en, mem_raddr, ins_valid, ins_data, ins_len, ins_pc,
    output mem_rdata, ins_ready
  );

endinterface

// File: rtl/i8080_oplen.sv
// i8080_oplen: combinational 8080 opcode -> instruction length (1..3), zero latency, no state.
// Undocumented aliases (CB, D9, DD, ED, FD) follow their documented twins.
module i8080_oplen
  import i8080_pkg::*;
(
  input  logic [7:0] i_opcode,
  output ins_len_t   o_len
);

  always_comb begin
    o_len = INS_LEN_1;
    casez (i_opcode)
      8'b00??0001, 8'h22, 8'h2A, 8'h32, 8'h3A,
      8'hC3, 8'hCB, 8'hCD, 8'hDD, 8'hED, 8'hFD,
      8'b11???010, 8'b11???100:                  o_len = INS_LEN_3;
      8'b00???110, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
      8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hD3, 8'hDB:  o_len = INS_LEN_2;
      default:                                   o_len = INS_LEN_1;
    endcase
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: 16-bit reads into a DEPTH-byte queue, one whole 1/2/3-byte instruction per handshake; ins_valid >= 2 cycles after issue.
// ins_ready low lets the queue fill and then stops issue (no ready->mem_rd_en path); FETCH_PERF_EN adds perf_stall_cnt.
module fetch_queue
  import i8080_pkg::*;
#(
  parameter int    DEPTH    = 8,
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          redirect,
  input  addr_t         redirect_pc,
  fetch_queue_if.master fq
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_1    = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_2    = PTR_W'(2);
  localparam logic [CNT_W:0]   ROOM_MAX = (CNT_W+1)'(DEPTH - 2);

  logic [7:0]       r_q [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  addr_t            r_fetch_pc, r_ins_pc;
  logic             r_inflight, r_squash;

  logic [7:0]       w_b0, w_b1, w_b2;
  ins_len_t         w_len;
  logic [CNT_W-1:0] w_len_c, w_add, w_sub;
  logic [CNT_W:0]   w_fill;
  logic             w_valid, w_issue, w_wr, w_hs;

  assign w_b0 = r_q[r_rd_ptr];
  assign w_b1 = r_q[r_rd_ptr + PTR_1];
  assign w_b2 = r_q[r_rd_ptr + PTR_2];

  i8080_oplen u_oplen (
    .i_opcode (w_b0),
    .o_len    (w_len)
  );

  assign w_len_c = {{(CNT_W-2){1'b0}}, w_len};
  assign w_valid = (r_count != '0) && (r_count >= w_len_c);

  // Space check counts the in-flight response but not this cycle's consume.
  assign w_fill  = {1'b0, r_count} + {{(CNT_W-1){1'b0}}, r_inflight, 1'b0};
  assign w_issue = rst_n && !halt && !redirect && (w_fill <= ROOM_MAX);
  assign w_wr    = r_inflight && !r_squash && !redirect;
  assign w_hs    = w_valid && fq.ins_ready && !redirect;
  assign w_add   = w_wr ? CNT_W'(2) : '0;
  assign w_sub   = w_hs ? w_len_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_PC;
      r_ins_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_squash   <= 1'b0;
    end else if (redirect) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_pc;
      r_ins_pc   <= redirect_pc;
      r_inflight <= 1'b0;
      r_squash   <= r_inflight;
    end else begin
      r_inflight <= w_issue;
      r_squash   <= 1'b0;
      r_count    <= r_count + w_add - w_sub;
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + PTR_2;
      if (w_issue)
        r_fetch_pc <= r_fetch_pc + 16'd2;
      if (w_hs) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_len);
        r_ins_pc <= r_ins_pc + addr_t'(w_len);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= 8'h00;
    end else if (w_wr) begin
      r_q[r_wr_ptr]         <= fq.mem_rdata[7:0];
      r_q[r_wr_ptr + PTR_1] <= fq.mem_rdata[15:8];
    end
  end

  assign fq.mem_rd_en = w_issue;
  assign fq.mem_raddr = r_fetch_pc;
  assign fq.ins_valid = w_valid;
  assign fq.ins_len   = w_len;
  assign fq.ins_pc    = r_ins_pc;
  assign fq.ins_data  = {w_b0,
                         (w_len != INS_LEN_1) ? w_b1 : 8'h00,
                         (w_len == INS_LEN_3) ? w_b2 : 8'h00};

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_perf <= '0;
    else if (fq.ins_ready && !w_valid && !redirect && (r_perf != 32'hFFFF_FFFF))
      r_perf <= r_perf + 32'd1;
  end

  assign perf_stall_cnt = r_perf;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a registered 64 KiB memory model and a delivery monitor.
module tb_fetch_queue;

  typedef struct {
    logic [23:0] data;
    logic [1:0]  len;
    logic [15:0] pc;
  } ins_rec_t;

  typedef struct {
    logic [7:0] op;
    logic [1:0] len;
  } op_vec_t;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  fetch_queue_if fq ();

  fetch_queue #(.DEPTH(8), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fq          (fq)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [7:0] mem [65536];
  ins_rec_t   got [$];
  int         errors = 0;
  int         checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (fq.mem_rd_en)
      fq.mem_rdata <= {mem[fq.mem_raddr + 16'd1], mem[fq.mem_raddr]};

  always @(negedge clk)
    if (rst_n && fq.ins_valid && fq.ins_ready && !redirect)
      got.push_back('{fq.ins_data, fq.ins_len, fq.ins_pc});

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_rec(input string name, input int idx, input ins_rec_t exp);
    if (idx >= got.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: instruction %0d missing, expected pc %0h", name, idx, exp.pc);
    end else begin
      chk($sformatf("%s[%0d].data", name, idx), 32'(got[idx].data), 32'(exp.data));
      chk($sformatf("%s[%0d].len",  name, idx), 32'(got[idx].len),  32'(exp.len));
      chk($sformatf("%s[%0d].pc",   name, idx), 32'(got[idx].pc),   32'(exp.pc));
    end
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (got.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, got %0d instructions expected %0d", name, got.size(), n);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] a);
    tick();
    redirect    = 1'b1;
    redirect_pc = a;
    tick();
    redirect = 1'b0;
    got.delete();
  endtask

  ins_rec_t prog [4];
  op_vec_t  opv  [32];
  ins_rec_t e;
  int       issues;
  logic [15:0] a;

  initial begin
    prog[0] = '{24'h000000, 2'd1, 16'h0000};
    prog[1] = '{24'h3E4200, 2'd2, 16'h0001};
    prog[2] = '{24'hC33412, 2'd3, 16'h0003};
    prog[3] = '{24'h000000, 2'd1, 16'h0006};

    opv[0]  = '{8'h00, 2'd1}; opv[1]  = '{8'h01, 2'd3}; opv[2]  = '{8'h11, 2'd3}; opv[3]  = '{8'h21, 2'd3};
    opv[4]  = '{8'h31, 2'd3}; opv[5]  = '{8'h22, 2'd3}; opv[6]  = '{8'h2A, 2'd3}; opv[7]  = '{8'h32, 2'd3};
    opv[8]  = '{8'h3A, 2'd3}; opv[9]  = '{8'hC3, 2'd3}; opv[10] = '{8'hCB, 2'd3}; opv[11] = '{8'hCD, 2'd3};
    opv[12] = '{8'hD9, 2'd1}; opv[13] = '{8'hDD, 2'd3}; opv[14] = '{8'hED, 2'd3}; opv[15] = '{8'hFD, 2'd3};
    opv[16] = '{8'hC2, 2'd3}; opv[17] = '{8'hFA, 2'd3}; opv[18] = '{8'hC4, 2'd3}; opv[19] = '{8'hFC, 2'd3};
    opv[20] = '{8'h06, 2'd2}; opv[21] = '{8'h3E, 2'd2}; opv[22] = '{8'hC6, 2'd2}; opv[23] = '{8'hFE, 2'd2};
    opv[24] = '{8'hD3, 2'd2}; opv[25] = '{8'hDB, 2'd2}; opv[26] = '{8'h76, 2'd1}; opv[27] = '{8'hC9, 2'd1};
    opv[28] = '{8'h02, 2'd1}; opv[29] = '{8'h0A, 2'd1}; opv[30] = '{8'hC7, 2'd1}; opv[31] = '{8'hE9, 2'd1};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'h3E; mem[2] = 8'h42;
    mem[3] = 8'hC3; mem[4] = 8'h34; mem[5] = 8'h12;
    mem[16'h0100] = 8'h06; mem[16'h0101] = 8'h77;
    for (int i = 0; i < 8; i++) mem[16'h0102 + i] = 8'(8'h78 + i);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(8'h40 + (i & 8'h3F));
    mem[16'h0300] = 8'h40; mem[16'h0301] = 8'h41; mem[16'h0302] = 8'h42; mem[16'h0303] = 8'h43;
    mem[16'h0304] = 8'hC3; mem[16'h0305] = 8'h34; mem[16'h0306] = 8'h12; mem[16'h0307] = 8'h49;
    a = 16'h0400;
    for (int i = 0; i < 32; i++) begin
      mem[a] = opv[i].op;
      if (opv[i].len >= 2) mem[a + 16'd1] = 8'hA5;
      if (opv[i].len == 3) mem[a + 16'd2] = 8'h5A;
      a = a + 16'(opv[i].len);
    end

    rst_n = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    fq.ins_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.mem_rd_en", 32'(fq.mem_rd_en), 32'h0);
    chk("rst.mem_raddr", 32'(fq.mem_raddr), 32'h0000);
    chk("rst.ins_valid", 32'(fq.ins_valid), 32'h0);
    chk("rst.ins_data",  32'(fq.ins_data),  32'h0);
    chk("rst.ins_len",   32'(fq.ins_len),   32'h1);
    chk("rst.ins_pc",    32'(fq.ins_pc),    32'h0000);

    // Program from reset: NOP, MVI, JMP
    tick();
    rst_n = 1'b1;
    fq.ins_ready = 1'b1;
    @(negedge clk);
    chk("first_issue.mem_rd_en", 32'(fq.mem_rd_en), 32'h1);
    wait_got("prog", 4, 40);
    for (int i = 0; i < 4; i++) cmp_rec("prog", i, prog[i]);

    // Length predecode table at 0x0400
    do_redirect(16'h0400);
    wait_got("oplen", 32, 300);
    a = 16'h0400;
    for (int i = 0; i < 32; i++) begin
      e.data = {opv[i].op, (opv[i].len >= 2) ? 8'hA5 : 8'h00, (opv[i].len == 3) ? 8'h5A : 8'h00};
      e.len  = opv[i].len;
      e.pc   = a;
      cmp_rec("oplen", i, e);
      a = a + 16'(opv[i].len);
    end

    // Backpressure for 20 cycles, then release
    fq.ins_ready = 1'b0;
    do_redirect(16'h0200);
    repeat (20) tick();
    @(negedge clk);
    chk("bp.mem_rd_en", 32'(fq.mem_rd_en), 32'h0);
    chk("bp.ins_valid", 32'(fq.ins_valid), 32'h1);
    chk("bp.ins_pc",    32'(fq.ins_pc),    32'h0200);
    chk("bp.ins_data",  32'(fq.ins_data),  32'h400000);
    tick();
    fq.ins_ready = 1'b1;
    wait_got("bp", 16, 100);
    for (int i = 0; i < 16; i++) begin
      e = '{{8'(8'h40 + i), 16'h0000}, 2'd1, 16'(16'h0200 + i)};
      cmp_rec("bp", i, e);
    end

    // Redirect to 0x0100 with a read in flight
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!fq.mem_rd_en && k < 30);
      chk("rdr.found_inflight", 32'(fq.mem_rd_en), 32'h1);
    end
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    chk("rdr.R.mem_rd_en", 32'(fq.mem_rd_en), 32'h0);
    tick();
    redirect = 1'b0;
    got.delete();
    @(negedge clk);
    chk("rdr.R1.mem_rd_en", 32'(fq.mem_rd_en), 32'h1);
    chk("rdr.R1.mem_raddr", 32'(fq.mem_raddr), 32'h0100);
    tick(); @(negedge clk);
    chk("rdr.R2.ins_valid", 32'(fq.ins_valid), 32'h0);
    tick(); @(negedge clk);
    chk("rdr.R3.ins_valid", 32'(fq.ins_valid), 32'h1);
    chk("rdr.R3.ins_pc",    32'(fq.ins_pc),    32'h0100);
    wait_got("rdr", 4, 30);
    cmp_rec("rdr", 0, '{24'h067700, 2'd2, 16'h0100});
    cmp_rec("rdr", 1, '{24'h780000, 2'd1, 16'h0102});
    cmp_rec("rdr", 2, '{24'h790000, 2'd1, 16'h0103});
    cmp_rec("rdr", 3, '{24'h7A0000, 2'd1, 16'h0104});

    // CALL across the 0xFFFF -> 0x0000 wrap
    mem[16'hFFFF] = 8'hCD; mem[0] = 8'h00; mem[1] = 8'h80; mem[2] = 8'h47; mem[3] = 8'h48;
    tick();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    got.delete();
    @(negedge clk);
    chk("wrap.R1.mem_raddr", 32'(fq.mem_raddr), 32'hFFFF);
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    chk("wrap.R3.ins_valid", 32'(fq.ins_valid), 32'h0);
    tick(); @(negedge clk);
    chk("wrap.R4.ins_valid", 32'(fq.ins_valid), 32'h1);
    wait_got("wrap", 3, 30);
    cmp_rec("wrap", 0, '{24'hCD0080, 2'd3, 16'hFFFF});
    cmp_rec("wrap", 1, '{24'h470000, 2'd1, 16'h0002});
    cmp_rec("wrap", 2, '{24'h480000, 2'd1, 16'h0003});

    // halt for 10 cycles after three issues from 0x0300
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0300;
    tick();
    redirect = 1'b0;
    got.delete();
    tick(); tick(); tick();
    halt = 1'b1;
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fq.mem_rd_en) issues++;
      tick();
    end
    @(negedge clk);
    chk("halt.issues",    32'(issues),       32'd0);
    chk("halt.delivered", 32'(got.size()),   32'd4);
    chk("halt.ins_valid", 32'(fq.ins_valid), 32'h0);
    chk("halt.ins_pc",    32'(fq.ins_pc),    32'h0304);
    tick();
    halt = 1'b0;
    @(negedge clk);
    chk("halt.resume.mem_rd_en", 32'(fq.mem_rd_en), 32'h1);
    chk("halt.resume.mem_raddr", 32'(fq.mem_raddr), 32'h0306);
    wait_got("halt", 5, 20);
    for (int i = 0; i < 4; i++)
      cmp_rec("halt", i, '{{8'(8'h40 + i), 16'h0000}, 2'd1, 16'(16'h0300 + i)});
    cmp_rec("halt", 4, '{24'hC33412, 2'd3, 16'h0304});

    // Reset mid-stream drops the queue
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.ins_valid", 32'(fq.ins_valid), 32'h0);
    chk("midrst.mem_rd_en", 32'(fq.mem_rd_en), 32'h0);
    chk("midrst.ins_pc",    32'(fq.ins_pc),    32'h0000);

`ifdef FETCH_PERF_EN
    halt = 1'b1;
    fq.ins_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    fq.ins_ready = 1'b1;
    repeat (5) tick();
    fq.ins_ready = 1'b0;
    @(negedge clk);
    chk("perf.stall_cnt", perf_stall_cnt, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
